// File: rtl/mux_rr_arb.sv
// ---------------------------------------------------------------------------
// mux_rr_arb
//
// Registered N-channel selector with a round-robin arbiter. Each cycle the
// output register can take a new beat, one valid input channel is granted.
// Its data is captured into a single output register, and the index of the
// winning channel is recorded with it. The block adds one cycle of latency and
// passes backpressure through. Drain and refill can happen in the same cycle,
// so a steady stream runs at one beat per cycle.
//
// Configuration macro:
//   MUX_ARB_FIXED_PRIO_EN  defined   -> fixed priority; the lowest-index valid
//                                       channel always wins; no pointer exists
//                          undefined -> round-robin arbitration (default)
//
// Parameters:
//   WIDTH  data width per channel (1..64)
//   N      channel count (2..8)
//   SW     width of a channel index, derived from N
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   [N]        per-channel request
//   in_data    [N*WIDTH]  channel k data at [k*WIDTH +: WIDTH]
//   in_ready   [N]        one-hot grant, or zero (combinational)
//   out_valid             output register holds a beat
//   out_data   [WIDTH]    registered data of the accepted beat
//   out_sel    [SW]       index of the channel that supplied out_data
//   out_ready             consumer accepts the beat this cycle
// ---------------------------------------------------------------------------
module mux_rr_arb #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_sel,
  input  logic               out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    sel_q, sel_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
  logic [SW-1:0]    ptr_q, ptr_d;
`endif

  logic          free;
  logic          grant_found;
  logic [SW-1:0] grant_idx;

  // The output register can take a new beat when it is empty, or when the
  // beat it holds leaves this cycle.
  assign free = (state_q == EMPTY) || out_ready;

  // Grant selection. Both loops run from the lowest-priority candidate to
  // the highest, so the last match (the highest-priority one) is the one
  // that is kept.
`ifdef MUX_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = SW'(k);
      end
    end
  end
`else
  // The candidate at offset i from the pointer is wrapped into 0..N-1 with a
  // single subtraction. That keeps it in range for non-power-of-two N.
  always_comb begin
    int            cand;
    logic [SW-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = SW'(cand);
      if (in_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end
`endif

  // While reset is high, the ready is held at zero. This way, no producer
  // sees a beat accepted in a cycle whose capture is discarded.
  always_comb begin
    in_ready = '0;
    if (!reset && free && grant_found) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic. A stalled register holds everything. A free register
  // either captures the granted beat or goes empty. When it goes empty, the
  // last data and index are kept.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    if (free) begin
      if (grant_found) begin
        state_d = FULL;
        data_d  = in_data[int'(grant_idx) * WIDTH +: WIDTH];
        sel_d   = grant_idx;
`ifndef MUX_ARB_FIXED_PRIO_EN
        if (int'(grant_idx) == N - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_idx + SW'(1);
        end
`endif
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // State register. Reset discards any held beat and restarts arbitration
  // at channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arb
//
// Self-checking bench for mux_rr_arb with WIDTH=16 and N=4. A reference model
// tracks the output register and the arbitration pointer as plain integers.
// It is checked against the DUT on every falling edge. Directed vectors with
// literal expectations pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_mux_rr_arb;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int SW    = 2;

  logic               clk;
  logic               reset;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Reference model state: the current value, and the value for after the next edge.
  bit               m_valid = 1'b0, n_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0,   n_data  = '0;
  int               m_sel   = 0,    n_sel   = 0;
  int               m_ptr   = 0,    n_ptr   = 0;

  mux_rr_arb #(
    .WIDTH(WIDTH),
    .N    (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one value and records the result.
  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives the control inputs. Callers do this just after a rising edge.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic rdy);
    reset     = rst;
    in_valid  = valid;
    out_ready = rdy;
  endtask

  task automatic setData(input int ch, input logic [WIDTH-1:0] val);
    in_data[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks the DUT outputs against literal values at the next falling edge.
  task automatic checkOutput(input string name, input logic [N-1:0] exp_ready,
                             input logic exp_valid, input logic [WIDTH-1:0] exp_data,
                             input int exp_sel);
    @(negedge clk);
    compare({name, ".in_ready"},  64'(in_ready),  64'(exp_ready));
    compare({name, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    compare({name, ".out_data"},  64'(out_data),  64'(exp_data));
    compare({name, ".out_sel"},   64'(out_sel),   64'(exp_sel));
  endtask

  // Reference model. The output register can accept a beat when it is empty or
  // being drained. If so, the winner is the first valid channel in circular
  // order from the pointer, or from channel 0 in the fixed-priority build.
  // The next state is worked out here and takes effect at the next rising edge.
  always @(negedge clk) begin
    bit           free;
    bit           found;
    int           g;
    int           start;
    int           c;
    logic [N-1:0] exp_ready;
    if (check_en) begin
      free      = !m_valid || out_ready;
      found     = 1'b0;
      g         = 0;
      exp_ready = '0;
`ifdef MUX_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      for (int k = 0; k < N; k++) begin
        c = (start + k) % N;
        if (!found && in_valid[c]) begin
          found = 1'b1;
          g     = c;
        end
      end
      if (!reset && free && found) exp_ready[g] = 1'b1;

      compare("model.in_ready",  64'(in_ready),  64'(exp_ready));
      compare("model.out_valid", 64'(out_valid), 64'(m_valid));
      compare("model.out_data",  64'(out_data),  64'(m_data));
      compare("model.out_sel",   64'(out_sel),   64'(m_sel));

      n_valid = m_valid;
      n_data  = m_data;
      n_sel   = m_sel;
      n_ptr   = m_ptr;
      if (reset) begin
        n_valid = 1'b0;
        n_data  = '0;
        n_sel   = 0;
        n_ptr   = 0;
      end else if (free) begin
        if (found) begin
          n_valid = 1'b1;
          n_data  = in_data[g*WIDTH +: WIDTH];
          n_sel   = g;
          n_ptr   = (g + 1) % N;
        end else begin
          n_valid = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    m_valid = n_valid;
    m_data  = n_data;
    m_sel   = n_sel;
    m_ptr   = n_ptr;
  end

  // Stops the run after a time bound, so the bench cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_data = '0;
    for (int k = 0; k < N; k++) setData(k, 16'h1234 + 16'(k));
    applyStimulus(1'b1, 4'b1111, 1'b1);
    step();
    step();
    check_en = 1'b1;
    checkOutput("reset", 4'b0000, 1'b0, 16'h0000, 0);

    step();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("first_grant", 4'b0001, 1'b0, 16'h0000, 0);

`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("fixed_prio", 4'b0001, 1'b1, 16'h1234, 0);
    end
    step();
    applyStimulus(1'b0, 4'b1110, 1'b1);
    checkOutput("fixed_drop0", 4'b0010, 1'b1, 16'h1234, 0);
    step();
    checkOutput("fixed_sel1", 4'b0010, 1'b1, 16'h1235, 1);
`else
    // The round-robin stream: each cycle shows one beat and grants the next channel.
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("rr_wrap", 4'(1 << ((i + 1) % 4)), 1'b1, 16'h1234 + 16'(i % 4), i % 4);
    end
    step();
    checkOutput("rr_extra", 4'b0010, 1'b1, 16'h1234, 0);

    // Backpressure while holding the channel 1 beat.
    step();
    applyStimulus(1'b0, 4'b1111, 1'b0);
    for (int j = 0; j < 3; j++) begin
      checkOutput("stall", 4'b0000, 1'b1, 16'h1235, 1);
      step();
    end
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("stall_release", 4'b0100, 1'b1, 16'h1235, 1);

    // Reset mid-operation, while FULL with the pointer at 3.
    step();
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("reset_mid", 4'b0000, 1'b1, 16'h1236, 2);
    step();
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("post_reset", 4'b0001, 1'b0, 16'h0000, 0);

    // A single channel, with data that is different from the default pattern.
    step();
    applyStimulus(1'b0, 4'b0100, 1'b1);
    setData(2, 16'h5678);
    checkOutput("single_ready", 4'b0100, 1'b1, 16'h1234, 0);
    step();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("single_out", 4'b0000, 1'b1, 16'h5678, 2);

    // Drained to EMPTY with the data held. With the pointer at 3, the scan wraps to channel 0.
    step();
    setData(2, 16'h1236);
    applyStimulus(1'b0, 4'b0011, 1'b1);
    checkOutput("empty_wrap", 4'b0001, 1'b0, 16'h5678, 2);
    step();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("wrap_out", 4'b0000, 1'b1, 16'h1234, 0);
`endif

    // Mixed traffic. Only the reference model checks these cycles.
    for (int i = 0; i < 40; i++) begin
      step();
      for (int k = 0; k < N; k++) setData(k, 16'($urandom));
      applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    step();
    applyStimulus(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised, registered N-channel selector that supersedes the fixed two-input 16-bit multiplexer. It selects one of `N` valid/ready input channels with a round-robin arbiter and captures the winner into a single output register. It sits between multiple producers (forwarding/writeback sources, bus masters) and one consumer in the p4/p5 datapath, adding one cycle of latency and full backpressure.

## Interface
- `WIDTH`, 16, data width per channel (1..64)
- `N`, 4, channel count (2..8); `SW = (N>2) ? $clog2(N) : 1`
- `clk`  input  1  rising-edge clock; only clock domain
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  N  per-channel request
- `in_data`  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- `in_ready`  output  N  one-hot or zero; channel k's beat is accepted when `in_valid[k] && in_ready[k]`
- `out_valid`  output  1  output register holds a beat
- `out_data`  output  WIDTH  registered data of the accepted beat
- `out_sel`  output  SW  index of the channel that supplied `out_data`
- `out_ready`  input  1  consumer accepts the beat when `out_valid && out_ready`

## Operation
- Internal state: output register (`out_valid`, `out_data`, `out_sel`) plus round-robin pointer `ptr` (SW bits, range 0..N-1).
- `free = !out_valid || out_ready`.
- Grant: when `free` and `|in_valid`, `g` is the first k with `in_valid[k]` scanning `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
- `in_ready = free ? (1 << g) : 0`. It is combinational, is zero when no input is valid, and is forced to 0 while `reset` is high.
- On a grant: `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`, `ptr <= (g == N-1) ? 0 : g+1`.
- When `free` and no input is valid: `out_valid <= 0`. `out_data` and `out_sel` hold, and `ptr` holds.
- When not `free` (`out_valid && !out_ready`): every register holds and `in_ready` is 0.
- The two states are EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
  - EMPTY→FULL on a grant.
  - FULL→FULL on a grant with `out_ready`, or on a stall.
  - FULL→EMPTY on `out_ready` with no input valid.
- Simultaneous drain and refill (`out_ready=1` while a grant occurs) runs at full throughput, with no bubble.
- For non-power-of-two N, `ptr` never takes values ≥ N.
- Input data of non-granted channels is ignored. A producer must hold `in_valid` and `in_data` stable until it is accepted.

## Timing
- Reset values, applied at the first rising edge with `reset=1`: `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
- `reset` has priority over all other activity. Asserting it mid-operation discards any held beat.
- Latency is 1 cycle: a beat accepted at edge T appears on `out_data` after edge T.
- Throughput is 1 beat per cycle while `out_ready=1`.
- Combinational paths:
  - `in_valid`/`out_ready`/`out_valid` → `in_ready`.
  - There is no combinational path from input to `out_data`.
- `out_data` and `out_sel` are stable for every cycle that `out_valid && !out_ready`.

## Configuration
- `MUX_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, where the lowest-index valid channel always wins; `ptr` is not implemented.
  - Undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `reset=1` for 2 cycles with `in_valid=4'b1111` and `out_ready=1`. Required: `in_ready=0`, `out_valid=0`, `out_data=16'h0000`, `out_sel=0`.
- Single channel: `in_valid=4'b0100`, ch2 data `16'h5678`, `out_ready=1`. Required: `in_ready=4'b0100` in the same cycle; next cycle `out_valid=1`, `out_data=16'h5678`, `out_sel=2`.
- Round-robin wrap: all four channels valid with data `16'h1234+k`, `out_ready=1` for 8 cycles. Required: `out_sel` sequence 0,1,2,3,0,1,2,3 with matching data and no bubbles.
- Backpressure: while FULL with `out_sel=1`, hold `out_ready=0` for 3 cycles. Required: `in_ready=4'b0000` and `out_data`/`out_sel` unchanged. After `out_ready=1` with all valid, the next `out_sel=2`.
- Reset mid-operation: assert `reset` for 1 cycle while FULL with `ptr=3`, then release with all valid. Required: `out_valid=0` for one cycle, then the first grant is `out_sel=0`.
- `MUX_ARB_FIXED_PRIO_EN` build: all channels valid with `out_ready=1` for 4 cycles. Required: `out_sel=0` every cycle. Then drop `in_valid[0]`: required `out_sel=1`.
